// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver
//
// Purpose: receives asynchronous serial frames on sysclk using 16x oversampling.
// Each bit is a majority vote of three samples. Words are delivered through a
// valid/ready handshake together with per-word parity and framing error flags.
// A sticky overrun flag is also reported.
//
// Ports:
//   sysclk      in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   UART_RX     in   asynchronous serial line
//   enable      in   low holds the receiver FSM idle
//   rx_ready    in   consumer accepts rx_data this cycle
//   err_clr     in   pulse clearing sticky overrun
//   rx_data     out  received word, first bit received in bit 0
//   rx_valid    out  rx_data and per-word flags are valid
//   parity_err  out  parity mismatch for the held word
//   frame_err   out  a stop bit was sampled low for the held word
//   overrun     out  sticky: a frame completed while rx_valid was high
//   busy        out  FSM is not idle
module uart_rx_param #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int INVERT    = 0
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 UART_RX,
    input  logic                 enable,
    input  logic                 rx_ready,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int DIV   = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BC_W  = $clog2(DATA_BITS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [BC_W-1:0]  LAST_BIT  = BC_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);
    localparam logic             INV       = (INVERT != 0);
    localparam logic             ODD       = (PARITY == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]           sync_q;
    logic                 rxs;
    logic [DIV_W-1:0]     div_q;
    logic                 tick;
    state_t               state_q, state_d;
    logic [3:0]           tc_q, tc_d;
    logic [2:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]      bitcnt_q, bitcnt_d;
    logic                 stopcnt_q, stopcnt_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 armed_q, armed_d;
    logic                 commit, commit_ferr, voted, stop_vote, accept;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, perr_out_q, ferr_out_q, ovr_q;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Synchronizer resets to the active (start) level so that armed can only
    // be set once the real line has been seen idle.
    always_ff @(posedge sysclk) begin
        if (reset) sync_q <= {2{INV}};
        else       sync_q <= {sync_q[0], UART_RX};
    end
    assign rxs = sync_q[1] ^ INV;

    // Free-running 16x tick; deliberately not realigned on start detection.
    always_ff @(posedge sysclk) begin
        if (reset)                 div_q <= '0;
        else if (div_q == DIV_LAST) div_q <= '0;
        else                        div_q <= div_q + 1'b1;
    end
    assign tick = (div_q == DIV_LAST);

    assign voted     = maj3(samp_q[0], samp_q[1], samp_q[2]);
    assign stop_vote = maj3(samp_q[0], samp_q[1], rxs);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tc_q      <= '0;
            samp_q    <= '0;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            stopcnt_q <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tc_q      <= tc_d;
            samp_q    <= samp_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            stopcnt_q <= stopcnt_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            armed_q   <= armed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tc_d        = tc_q;
        samp_d      = samp_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        stopcnt_d   = stopcnt_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        armed_d     = armed_q;
        commit      = 1'b0;
        commit_ferr = ferr_q | ~stop_vote;

        if (tick) begin
            tc_d = tc_q + 4'd1;
            case (tc_q)
                4'd7:    samp_d[0] = rxs;
                4'd8:    samp_d[1] = rxs;
                4'd9:    samp_d[2] = rxs;
                default: ;
            endcase
        end

        unique case (state_q)
            S_IDLE: begin
                tc_d = '0;
                if (rxs) armed_d = 1'b1;
                if (enable && !rxs && armed_q) state_d = S_START;
            end
            // The start bit is validated at mid-bit. DATA begins at the end of
            // the start bit, so every later bit is voted around its own middle.
            S_START: if (tick) begin
                if (tc_q == 4'd8 && rxs) begin
                    state_d = S_IDLE;
                    tc_d    = '0;
                end else if (tc_q == 4'd15) begin
                    state_d   = S_DATA;
                    tc_d      = '0;
                    bitcnt_d  = '0;
                    stopcnt_d = 1'b0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                end
            end
            S_DATA: if (tick && tc_q == 4'd15) begin
                shreg_d = {voted, shreg_q[DATA_BITS-1:1]};
                tc_d    = '0;
                if (bitcnt_q == LAST_BIT) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                else                      bitcnt_d = bitcnt_q + 1'b1;
            end
            S_PARITY: if (tick && tc_q == 4'd15) begin
                perr_d  = ((^shreg_q) ^ voted) != ODD;
                state_d = S_STOP;
                tc_d    = '0;
            end
            // Commit at the vote of the last stop bit, without waiting for its end.
            S_STOP: if (tick) begin
                if (tc_q == 4'd9) begin
                    if (stopcnt_q == LAST_STOP) begin
                        commit  = 1'b1;
                        state_d = S_IDLE;
                        tc_d    = '0;
                    end else begin
                        ferr_d = commit_ferr;
                    end
                end else if (tc_q == 4'd15) begin
                    stopcnt_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!enable) begin
            state_d = S_IDLE;
            tc_d    = '0;
            commit  = 1'b0;
        end
        // A low stop bit may be a break; require an idle line before the next start.
        if (commit && commit_ferr) armed_d = 1'b0;
    end

    assign accept = commit && (!valid_q || rx_ready);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            if (accept) begin
                data_q     <= shreg_q;
                perr_out_q <= perr_q;
                ferr_out_q <= commit_ferr;
                valid_q    <= 1'b1;
            end else if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
            if (commit && !accept) ovr_q <= 1'b1;
            else if (err_clr)      ovr_q <= 1'b0;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != S_IDLE);
endmodule
